// File: rtl/multichannel_fir_equalizer_pkg.sv
// Shared types and arithmetic helpers for the multichannel FIR equalizer.
package eq_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, MAC, ROUND, OUT} eq_state_e;

   // Q2.(coef_w-2) representation of 1.0
   function automatic int unity_coef(input int coef_w);
      return 1 << (coef_w - 2);
   endfunction

   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   function automatic longint saturate(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/multichannel_fir_equalizer_if.sv
// Coefficient write bus and parallel PCM output bus of the equalizer.
interface multichannel_fir_equalizer_if #(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int NUM_CH   = 2,
   parameter int NUM_TAPS = 8
);
   localparam int TAW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              coef_we;
   logic [TAW-1:0]    coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic              coef_commit;
   logic [DATA_W-1:0] pcm_out;
   logic [CHW-1:0]    pcm_ch;
   logic              pcm_valid;

   modport master (output coef_we, coef_addr, coef_data, coef_commit,
                   input  pcm_out, pcm_ch, pcm_valid);
   modport slave  (input  coef_we, coef_addr, coef_data, coef_commit,
                   output pcm_out, pcm_ch, pcm_valid);
endinterface

// File: rtl/multichannel_fir_equalizer_serial_rx.sv
// DSP-mode serial deserialiser: word strobe per channel, early-SFS detection.
module eq_serial_rx #(
   parameter int DATA_W = 16,
   parameter int NUM_CH = 2,
   parameter int CHW    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sfs,
   input  logic                     d,
   output logic                     word_done,
   output logic [CHW-1:0]           word_ch,
   output logic signed [DATA_W-1:0] word,
   output logic                     frame_err
);
   localparam int BW = $clog2(DATA_W);
   localparam int CW = $clog2(NUM_CH + 1);

   logic [BW-1:0]     bit_q;
   logic [CW-1:0]     ch_cnt_q;
   logic [DATA_W-2:0] sr_q;
   logic              active, last_bit, final_word, err;

   // ch_cnt_q == NUM_CH means the frame is complete or no SFS seen yet
   assign active     = ch_cnt_q < CW'(NUM_CH);
   assign last_bit   = bit_q == BW'(DATA_W - 1);
   assign final_word = ch_cnt_q == CW'(NUM_CH - 1);
   // SFS may legally overlap the final bit of the final word
   assign word_done  = active && last_bit && (!sfs || final_word);
   assign err        = sfs && active && (bit_q != '0) && !(last_bit && final_word);
   assign word       = {sr_q, d};
   assign word_ch    = CHW'(ch_cnt_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_q     <= '0;
         ch_cnt_q  <= CW'(NUM_CH);
         sr_q      <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= err;
         if (sfs) begin
            bit_q    <= '0;
            ch_cnt_q <= '0;
         end else if (active) begin
            sr_q <= {sr_q[DATA_W-3:0], d};
            if (last_bit) begin
               bit_q    <= '0;
               ch_cnt_q <= ch_cnt_q + 1'b1;
            end else begin
               bit_q <= bit_q + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/multichannel_fir_equalizer.sv
// Per-channel FIR over a serial audio stream using one time-shared MAC.
module multichannel_fir_equalizer
   import eq_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int COEF_W     = 16,
   parameter int NUM_CH     = 2,
   parameter int NUM_TAPS   = 8,
   parameter int FRAME_BITS = 32
) (
   input  logic                         SCK,
   input  logic                         reset,
   input  logic                         SFS,
   input  logic                         D,
   input  logic                         bypass,
   input  logic                         clip_clr,
   multichannel_fir_equalizer_if.slave  bus,
   output logic [NUM_CH-1:0]            clip,
   output logic                         frame_err,
   output logic                         commit_pending
);
   localparam int TAW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW  = acc_width(DATA_W, COEF_W, NUM_TAPS);
   localparam int PW  = DATA_W + COEF_W;
   localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(unity_coef(COEF_W));
   localparam logic signed [AW-1:0]     RND   = AW'(unity_coef(COEF_W) >> 1);

   if (FRAME_BITS < NUM_CH * DATA_W || NUM_TAPS + 3 > DATA_W) begin : g_bad_cfg
      $error("multichannel_fir_equalizer: illegal parameter set");
   end

   logic                     word_done;
   logic [CHW-1:0]           word_ch;
   logic signed [DATA_W-1:0] word;

   eq_serial_rx #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CHW(CHW)) u_rx (
      .clk(SCK), .rst_n(reset), .sfs(SFS), .d(D),
      .word_done(word_done), .word_ch(word_ch), .word(word), .frame_err(frame_err)
   );

   eq_state_e                state_q, state_d;
   logic signed [COEF_W-1:0] shadow_q [NUM_TAPS];
   logic signed [COEF_W-1:0] shadow_d [NUM_TAPS];
   logic signed [COEF_W-1:0] active_q [NUM_TAPS];
   logic signed [DATA_W-1:0] dl_q [NUM_CH][NUM_TAPS];
   logic [TAW-1:0]           wp_q [NUM_CH];
   logic signed [DATA_W-1:0] x_q;
   logic [CHW-1:0]           ch_q;
   logic                     byp_q, armed_q;
   logic signed [AW-1:0]     acc_q, rnd;
   logic [TAW-1:0]           k_q, rd_q;
   logic signed [PW-1:0]     prod;
   logic                     accept, copy_ok, arm, do_copy, clip_hit;
   logic [NUM_CH-1:0]        clip_set;
   longint                   rl, sat_v;

   assign accept  = word_done && (state_q == IDLE || state_q == OUT);
   // Bank swap only between jobs so a frame never mixes coefficient sets
   assign copy_ok = (state_q == IDLE || state_q == OUT) && !word_done;
   assign arm     = commit_pending && (SFS || armed_q);
   assign do_copy = arm && copy_ok;

   always_comb begin
      for (int i = 0; i < NUM_TAPS; i++) shadow_d[i] = shadow_q[i];
      if (bus.coef_we && int'(bus.coef_addr) < NUM_TAPS) shadow_d[bus.coef_addr] = bus.coef_data;
   end

   always_ff @(posedge SCK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            shadow_q[i] <= (i == 0) ? UNITY : '0;
            active_q[i] <= (i == 0) ? UNITY : '0;
         end
         commit_pending <= 1'b0;
         armed_q        <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_TAPS; i++) shadow_q[i] <= shadow_d[i];
         if (do_copy)
            for (int i = 0; i < NUM_TAPS; i++) active_q[i] <= shadow_d[i];
         commit_pending <= bus.coef_commit || (commit_pending && !do_copy);
         armed_q        <= arm && !do_copy;
      end
   end

   always_ff @(posedge SCK or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (word_done) state_d = LOAD;
         LOAD:    state_d = MAC;
         MAC:     if (k_q == TAW'(NUM_TAPS - 1)) state_d = ROUND;
         ROUND:   state_d = OUT;
         OUT:     state_d = word_done ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign prod = PW'(dl_q[ch_q][rd_q]) * PW'(active_q[k_q]);
   assign rnd  = (acc_q + RND) >>> (COEF_W - 2);

   always_comb begin
      rl       = longint'(rnd);
      sat_v    = saturate(rl, DATA_W);
      clip_hit = sat_v != rl;
      clip_set = '0;
      if (state_q == ROUND && !byp_q && clip_hit) clip_set[ch_q] = 1'b1;
   end

   always_ff @(posedge SCK or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wp_q[c] <= '0;
            for (int t = 0; t < NUM_TAPS; t++) dl_q[c][t] <= '0;
         end
         x_q <= '0; ch_q <= '0; byp_q <= 1'b0; acc_q <= '0; k_q <= '0; rd_q <= '0;
         bus.pcm_out <= '0; bus.pcm_ch <= '0; bus.pcm_valid <= 1'b0; clip <= '0;
      end else begin
         bus.pcm_valid <= 1'b0;
         clip          <= (clip & ~{NUM_CH{clip_clr}}) | clip_set;
         if (accept) begin
            x_q  <= word;
            ch_q <= word_ch;
         end
         case (state_q)
            LOAD: begin
               dl_q[ch_q][wp_q[ch_q]] <= x_q;
               wp_q[ch_q] <= (wp_q[ch_q] == TAW'(NUM_TAPS - 1)) ? '0 : wp_q[ch_q] + 1'b1;
               rd_q  <= wp_q[ch_q];
               byp_q <= bypass;
               acc_q <= '0;
               k_q   <= '0;
            end
            MAC: begin
               // rd_q walks backwards through the ring: x[n], x[n-1], ...
               acc_q <= acc_q + AW'(prod);
               k_q   <= k_q + 1'b1;
               rd_q  <= (rd_q == '0) ? TAW'(NUM_TAPS - 1) : rd_q - 1'b1;
            end
            ROUND: begin
               bus.pcm_out   <= byp_q ? x_q : sat_v[DATA_W-1:0];
               bus.pcm_ch    <= ch_q;
               bus.pcm_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_multichannel_fir_equalizer.sv
// Directed bench: identity, averaging, saturation, bypass, early SFS, mid-job reset.
module tb_multichannel_fir_equalizer;
   logic       SCK = 1'b0, reset = 1'b0, SFS = 1'b0, D = 1'b0, bypass = 1'b0, clip_clr = 1'b0;
   logic [1:0] clip;
   logic       frame_err, commit_pending;

   multichannel_fir_equalizer_if #(.DATA_W(16), .COEF_W(16), .NUM_CH(2), .NUM_TAPS(8)) bus ();

   multichannel_fir_equalizer #(.DATA_W(16), .COEF_W(16), .NUM_CH(2), .NUM_TAPS(8), .FRAME_BITS(32)) dut (
      .SCK(SCK), .reset(reset), .SFS(SFS), .D(D), .bypass(bypass), .clip_clr(clip_clr),
      .bus(bus), .clip(clip), .frame_err(frame_err), .commit_pending(commit_pending)
   );

   always #5 SCK = ~SCK;

   typedef struct { int ch; logic [15:0] v; int t; } ev_t;
   ev_t evq[$];
   int  cyc = 0, n_tests = 0, n_fail = 0, n_ferr = 0;
   int  last_t [2];

   always @(posedge SCK) cyc++;
   always @(negedge SCK) begin
      if (bus.pcm_valid === 1'b1) evq.push_back('{int'(bus.pcm_ch), bus.pcm_out, cyc});
      if (frame_err === 1'b1) n_ferr++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge SCK); #1; end
   endtask

   task automatic do_reset();
      reset = 1'b0; step(2); reset = 1'b1; step(1);
   endtask

   task automatic wr_coef(input logic [2:0] a, input logic [15:0] v);
      bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = v; step(1); bus.coef_we = 1'b0;
   endtask

   task automatic commit();
      bus.coef_commit = 1'b1; step(1); bus.coef_commit = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
      logic [15:0] w [2];
      w[0] = l; w[1] = r;
      SFS = 1'b1; step(1); SFS = 1'b0;
      for (int c = 0; c < 2; c++)
         for (int b = 15; b >= 0; b--) begin
            D = w[c][b]; step(1);
            if (b == 0) last_t[c] = cyc;
         end
      D = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic [15:0] l, input logic [15:0] r,
                            input logic [15:0] el, input logic [15:0] er);
      evq.delete();
      send_frame(l, r);
      step(12);
      chk({tag, "_nvalid"}, evq.size(), 2);
      if (evq.size() == 2) begin
         chk({tag, "_ch0"},  evq[0].ch, 0);
         chk({tag, "_out0"}, evq[0].v, el);
         chk({tag, "_lat0"}, evq[0].t - last_t[0], 10);
         chk({tag, "_ch1"},  evq[1].ch, 1);
         chk({tag, "_out1"}, evq[1].v, er);
         chk({tag, "_lat1"}, evq[1].t - last_t[1], 10);
      end
   endtask

   initial begin
      bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.coef_commit = 1'b0;
      step(3);
      chk("rst_valid", bus.pcm_valid, 0);
      chk("rst_out", bus.pcm_out, 0);
      chk("rst_clip", clip, 0);
      chk("rst_pend", commit_pending, 0);
      reset = 1'b1; step(2);

      // identity filter out of reset
      run_frame("ident", 16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC);
      chk("ident_clip", clip, 0);

      // 2-tap average, committed at the next SFS
      do_reset();
      wr_coef(3'd0, 16'h2000); wr_coef(3'd1, 16'h2000); commit();
      chk("avg_pend_set", commit_pending, 1);
      run_frame("avg1", 16'h4000, 16'h0000, 16'h2000, 16'h0000);
      chk("avg_pend_clr", commit_pending, 0);
      run_frame("avg2", 16'h4000, 16'h0000, 16'h4000, 16'h0000);

      // positive and negative saturation, sticky flags
      do_reset();
      wr_coef(3'd0, 16'h7FFF); commit();
      run_frame("satp", 16'h7000, 16'h0000, 16'h7FFF, 16'h0000);
      chk("satp_clip", clip, 2'b01);
      run_frame("satn", 16'h1000, 16'h8000, 16'h2000, 16'h8000);
      chk("satn_clip", clip, 2'b11);
      clip_clr = 1'b1; step(1); clip_clr = 1'b0;
      chk("clip_clr", clip, 2'b00);

      // bypass returns raw sample at the same latency
      do_reset();
      wr_coef(3'd0, 16'h0000); commit();
      bypass = 1'b1;
      run_frame("byp", 16'hABCD, 16'h1111, 16'hABCD, 16'h1111);
      bypass = 1'b0;
      run_frame("nobyp", 16'hABCD, 16'h1111, 16'h0000, 16'h0000);

      // early SFS at bit 7 of ch0, then resync
      do_reset();
      n_ferr = 0;
      SFS = 1'b1; step(1); SFS = 1'b0;
      for (int b = 0; b < 7; b++) begin D = 1'b1; step(1); end
      run_frame("resync", 16'h0BEE, 16'h1357, 16'h0BEE, 16'h1357);
      chk("ferr_pulses", n_ferr, 1);

      // reset during MAC: no output, identity restored
      do_reset();
      run_frame("pre", 16'h1234, 16'h4321, 16'h1234, 16'h4321);
      wr_coef(3'd0, 16'h0000); commit();
      evq.delete();
      SFS = 1'b1; step(1); SFS = 1'b0;
      for (int b = 15; b >= 0; b--) begin D = b[0]; step(1); end
      D = 1'b0;
      step(5);
      reset = 1'b0; #2;
      chk("mrst_valid", bus.pcm_valid, 0);
      chk("mrst_out", bus.pcm_out, 0);
      chk("mrst_pend", commit_pending, 0);
      step(2); reset = 1'b1;
      step(20);
      chk("mrst_novalid", evq.size(), 0);
      run_frame("post", 16'h0F0F, 16'hF0F0, 16'h0F0F, 16'hF0F0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
